// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU operation codes, enable levels, RV32I opcodes
// and the decode-to-execute bundle.
package cpu_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef enum logic [4:0] {
        ALU_NONE = 5'd0,
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_JAL, ALU_JALR,
        ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
    } alu_code_e;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;

    typedef struct packed {
        alu_code_e             alu_code;
        logic [WORD_W-1:0]     op1;
        logic [WORD_W-1:0]     op2;
        logic [WORD_W-1:0]     br_base;
        logic [WORD_W-1:0]     imm;
        logic [WORD_W-1:0]     pc;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_we;
        logic                  mem_re;
        logic                  mem_we;
        logic [2:0]            mem_funct3;
        logic [WORD_W-1:0]     store_data;
        logic                  illegal;
    } ex_bundle_t;

    // Register-register and register-immediate arithmetic share one funct3 map;
    // alt selects SUB/SRA.
    function automatic alu_code_e arith_code(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction (I/S/B/U/J), format chosen by opcode,
// sign-extended from inst[31].
module imm_gen
    import cpu_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves imm unassigned (no latch).
        imm = '0;
        case (inst[6:0])
            OP_IMM, JALR, LOAD: imm = {{20{inst[31]}}, inst[31:20]};
            STORE:              imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            BRANCH:             imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            LUI, AUIPC:         imm = {inst[31:12], 12'b0};
            JAL:                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:            imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: accepts an instruction over valid/ready, decodes it against
// combinational register reads, and presents one registered execute bundle.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = WORD_W,
    parameter int unsigned RA_W = REG_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [RA_W-1:0] rs1_addr,
    output logic [RA_W-1:0] rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      alu_code,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] br_base,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc,
    output logic [RA_W-1:0] rd,
    output logic            reg_we,
    output logic            mem_re,
    output logic            mem_we,
    output logic [2:0]      mem_funct3,
    output logic [XLEN-1:0] store_data,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_val;
    logic            accept;
    logic            bad;
    ex_bundle_t      dec;
    ex_bundle_t      bundle_d, bundle_q;
    logic            valid_d, valid_q;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign funct7   = in_instr[31:25];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    imm_gen u_imm_gen (
        .inst (in_instr),
        .imm  (imm_val)
    );

    always_comb begin
        dec    = '0;
        bad    = 1'b0;
        dec.pc = in_pc;
        dec.rd = in_instr[11:7];
        case (opcode)
            OP: begin
                dec.alu_code = arith_code(funct3, funct7[5]);
                dec.op1      = rs1_data;
                dec.op2      = rs2_data;
                dec.reg_we   = ENABLE;
                bad = !((funct7 == 7'h00) ||
                        (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OP_IMM: begin
                dec.alu_code = arith_code(funct3, in_instr[30] && funct3 == 3'b101);
                dec.op1      = rs1_data;
                // Shifts use only the low five immediate bits; bit 30 is the SRAI select.
                dec.op2      = (funct3 == 3'b001 || funct3 == 3'b101)
                             ? {{(XLEN-5){1'b0}}, imm_val[4:0]} : imm_val;
                dec.imm      = imm_val;
                dec.reg_we   = ENABLE;
            end
            LUI: begin
                dec.alu_code = ALU_LUI;
                dec.op2      = imm_val;
                dec.imm      = imm_val;
                dec.reg_we   = ENABLE;
            end
            AUIPC: begin
                dec.alu_code = ALU_ADD;
                dec.op1      = in_pc;
                dec.op2      = imm_val;
                dec.imm      = imm_val;
                dec.reg_we   = ENABLE;
            end
            JAL: begin
                dec.alu_code = ALU_JAL;
                dec.op1      = in_pc;
                dec.br_base  = in_pc;
                dec.imm      = imm_val;
                dec.reg_we   = ENABLE;
            end
            JALR: begin
                dec.alu_code = ALU_JALR;
                dec.op1      = in_pc;
                dec.br_base  = rs1_data;
                dec.imm      = imm_val;
                dec.reg_we   = ENABLE;
            end
            BRANCH: begin
                case (funct3)
                    3'b000:  dec.alu_code = ALU_BEQ;
                    3'b001:  dec.alu_code = ALU_BNE;
                    3'b100:  dec.alu_code = ALU_BLT;
                    3'b101:  dec.alu_code = ALU_BGE;
                    3'b110:  dec.alu_code = ALU_BLTU;
                    3'b111:  dec.alu_code = ALU_BGEU;
                    default: bad = 1'b1;
                endcase
                dec.op1     = rs1_data;
                dec.op2     = rs2_data;
                dec.br_base = in_pc;
                dec.imm     = imm_val;
            end
            LOAD: begin
                dec.alu_code   = ALU_ADD;
                dec.op1        = rs1_data;
                dec.op2        = imm_val;
                dec.imm        = imm_val;
                dec.mem_re     = ENABLE;
                dec.reg_we     = ENABLE;
                dec.mem_funct3 = funct3;
            end
            STORE: begin
                dec.alu_code   = ALU_ADD;
                dec.op1        = rs1_data;
                dec.op2        = imm_val;
                dec.imm        = imm_val;
                dec.mem_we     = ENABLE;
                dec.mem_funct3 = funct3;
                dec.store_data = rs2_data;
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.rd      = in_instr[11:7];
            dec.illegal = 1'b1;
        end else if (dec.rd == '0) begin
            dec.reg_we = DISABLE;
        end
    end

    always_comb begin
        bundle_d = bundle_q;
        valid_d  = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid  = valid_q;
    assign alu_code   = bundle_q.alu_code;
    assign op1        = bundle_q.op1;
    assign op2        = bundle_q.op2;
    assign br_base    = bundle_q.br_base;
    assign imm        = bundle_q.imm;
    assign pc         = bundle_q.pc;
    assign rd         = bundle_q.rd;
    assign reg_we     = bundle_q.reg_we;
    assign mem_re     = bundle_q.mem_re;
    assign mem_we     = bundle_q.mem_we;
    assign mem_funct3 = bundle_q.mem_funct3;
    assign store_data = bundle_q.store_data;
    assign illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, handshake corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_decode_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr, alu_code, rd;
    logic [31:0] op1, op2, br_base, imm, pc, store_data;
    logic        reg_we, mem_re, mem_we, illegal;
    logic [2:0]  mem_funct3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_code(alu_code), .op1(op1), .op2(op2), .br_base(br_base), .imm(imm), .pc(pc),
        .rd(rd), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
        .mem_funct3(mem_funct3), .store_data(store_data), .illegal(illegal)
    );

    typedef struct {
        logic [31:0] instr, pcv, rs1, rs2;
        alu_code_e   code;
        logic [31:0] e_op1, e_op2, e_br, e_imm;
        logic [3:0]  flags;  // {reg_we, mem_re, mem_we, illegal}
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic ex_bundle_t dut_bundle();
        ex_bundle_t b;
        b.alu_code   = alu_code_e'(alu_code);
        b.op1        = op1;
        b.op2        = op2;
        b.br_base    = br_base;
        b.imm        = imm;
        b.pc         = pc;
        b.rd         = rd;
        b.reg_we     = reg_we;
        b.mem_re     = mem_re;
        b.mem_we     = mem_we;
        b.mem_funct3 = mem_funct3;
        b.store_data = store_data;
        b.illegal    = illegal;
        return b;
    endfunction

    task automatic check_bundle(input string name, input ex_bundle_t exp);
        ex_bundle_t got;
        got = dut_bundle();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference decode built from the ISA field definitions using integer arithmetic.
    function automatic ex_bundle_t model_decode(input logic [31:0] w, input logic [31:0] pcv,
                                                input logic [31:0] a, input logic [31:0] b);
        ex_bundle_t e;
        alu_code_e  arith [8];
        alu_code_e  brc   [8];
        int         f3, i_imm, s_imm, b_imm, j_imm;
        logic [31:0] u_imm;
        logic       bad;
        arith = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        brc   = '{ALU_BEQ, ALU_BNE, ALU_NONE, ALU_NONE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
        f3    = int'(w[14:12]);
        i_imm = int'(w[31:20]);                              if (w[31]) i_imm -= 4096;
        s_imm = int'(w[31:25]) * 32 + int'(w[11:7]);         if (w[31]) s_imm -= 4096;
        b_imm = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (w[31]) b_imm -= 4096;
        j_imm = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        if (w[31]) j_imm -= 1048576;
        u_imm = w & 32'hFFFF_F000;
        bad = 1'b0;
        e = '0;
        e.pc = pcv;
        e.rd = w[11:7];
        case (w[6:0])
            OP: begin
                e.alu_code = arith[f3];
                if (w[31:25] == 7'h20 && f3 == 0) e.alu_code = ALU_SUB;
                else if (w[31:25] == 7'h20 && f3 == 5) e.alu_code = ALU_SRA;
                else if (w[31:25] != 7'h00) bad = 1'b1;
                e.op1 = a; e.op2 = b; e.reg_we = 1'b1;
            end
            OP_IMM: begin
                e.alu_code = (f3 == 5 && w[30]) ? ALU_SRA : arith[f3];
                e.op1 = a;
                e.op2 = (f3 == 1 || f3 == 5) ? 32'(w[24:20]) : i_imm;
                e.imm = i_imm; e.reg_we = 1'b1;
            end
            LUI:   begin e.alu_code = ALU_LUI; e.op2 = u_imm; e.imm = u_imm; e.reg_we = 1'b1; end
            AUIPC: begin e.alu_code = ALU_ADD; e.op1 = pcv; e.op2 = u_imm; e.imm = u_imm; e.reg_we = 1'b1; end
            JAL:   begin e.alu_code = ALU_JAL; e.op1 = pcv; e.br_base = pcv; e.imm = j_imm; e.reg_we = 1'b1; end
            JALR:  begin e.alu_code = ALU_JALR; e.op1 = pcv; e.br_base = a; e.imm = i_imm; e.reg_we = 1'b1; end
            BRANCH: begin
                bad = (f3 == 2 || f3 == 3);
                e.alu_code = brc[f3];
                e.op1 = a; e.op2 = b; e.br_base = pcv; e.imm = b_imm;
            end
            LOAD: begin
                e.alu_code = ALU_ADD; e.op1 = a; e.op2 = i_imm; e.imm = i_imm;
                e.mem_re = 1'b1; e.reg_we = 1'b1; e.mem_funct3 = w[14:12];
            end
            STORE: begin
                e.alu_code = ALU_ADD; e.op1 = a; e.op2 = s_imm; e.imm = s_imm;
                e.mem_we = 1'b1; e.mem_funct3 = w[14:12]; e.store_data = b;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            e = '0;
            e.pc = pcv;
            e.rd = w[11:7];
            e.illegal = 1'b1;
        end else if (w[11:7] == 5'd0) begin
            e.reg_we = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [10];
        logic [31:0] w;
        int          k;
        opcs = '{OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, 7'h7F};
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 10) w[6:0] = opcs[k];
        if (w[6:0] == OP && $urandom_range(0, 3) != 0)
            w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] pcv,
                         input logic [31:0] a, input logic [31:0] b);
        in_instr = w; in_pc = pcv; rs1_data = a; rs2_data = b;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t       vecs [$];
        ex_bundle_t q [$];
        logic       acc;

        vecs.push_back('{32'h00500093, 32'h100, 32'h0,  32'h0,  ALU_ADD,  32'h0,   32'h5,        32'h0,   32'h5,        4'b1000});
        vecs.push_back('{32'hFE209EE3, 32'h200, 32'h11, 32'h22, ALU_BNE,  32'h11,  32'h22,       32'h200, 32'hFFFFFFFC, 4'b0000});
        vecs.push_back('{32'h008000EF, 32'h300, 32'h5,  32'h6,  ALU_JAL,  32'h300, 32'h0,        32'h300, 32'h8,        4'b1000});
        vecs.push_back('{32'h123452B7, 32'h0,   32'h7,  32'h8,  ALU_LUI,  32'h0,   32'h12345000, 32'h0,   32'h12345000, 4'b1000});
        vecs.push_back('{32'hFFFFF317, 32'h400, 32'h1,  32'h2,  ALU_ADD,  32'h400, 32'hFFFFF000, 32'h0,   32'hFFFFF000, 4'b1000});
        vecs.push_back('{32'h00208033, 32'h0,   32'h3,  32'h4,  ALU_ADD,  32'h3,   32'h4,        32'h0,   32'h0,        4'b0000});
        vecs.push_back('{32'h402081B3, 32'h0,   32'h9,  32'h2,  ALU_SUB,  32'h9,   32'h2,        32'h0,   32'h0,        4'b1000});
        vecs.push_back('{32'h4030D213, 32'h0,   32'hF0, 32'h0,  ALU_SRA,  32'hF0,  32'h3,        32'h0,   32'h403,      4'b1000});
        vecs.push_back('{32'hFFC12183, 32'h0,   32'h80, 32'h0,  ALU_ADD,  32'h80,  32'hFFFFFFFC, 32'h0,   32'hFFFFFFFC, 4'b1100});
        vecs.push_back('{32'h00112423, 32'h0,   32'h40, 32'hAB, ALU_ADD,  32'h40,  32'h8,        32'h0,   32'h8,        4'b0010});
        vecs.push_back('{32'h000080E7, 32'h500, 32'h77, 32'h0,  ALU_JALR, 32'h500, 32'h0,        32'h77,  32'h0,        4'b1000});
        vecs.push_back('{32'h0000007F, 32'h600, 32'h1,  32'h2,  ALU_NONE, 32'h0,   32'h0,        32'h0,   32'h0,        4'b0001});
        vecs.push_back('{32'h00002063, 32'h700, 32'h1,  32'h2,  ALU_NONE, 32'h0,   32'h0,        32'h0,   32'h0,        4'b0001});
        vecs.push_back('{32'h02208033, 32'h800, 32'h1,  32'h2,  ALU_NONE, 32'h0,   32'h0,        32'h0,   32'h0,        4'b0001});

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) step();
        rst = 1'b0;
        check("reset_out_valid", out_valid, 0);
        check_bundle("reset_bundle", '0);
        check("reset_in_ready", in_ready, 1);

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            drive(vecs[i].instr, vecs[i].pcv, vecs[i].rs1, vecs[i].rs2);
            #1;
            check($sformatf("vec%0d_rs_addr", i), {rs1_addr, rs2_addr}, {vecs[i].instr[19:15], vecs[i].instr[24:20]});
            step();
            in_valid = 1'b0;
            check($sformatf("vec%0d_out_valid", i), out_valid, 1);
            check($sformatf("vec%0d_alu_code", i), alu_code, vecs[i].code);
            check($sformatf("vec%0d_op1", i), op1, vecs[i].e_op1);
            check($sformatf("vec%0d_op2", i), op2, vecs[i].e_op2);
            check($sformatf("vec%0d_br_base", i), br_base, vecs[i].e_br);
            check($sformatf("vec%0d_imm", i), imm, vecs[i].e_imm);
            check($sformatf("vec%0d_flags", i), {reg_we, mem_re, mem_we, illegal}, vecs[i].flags);
            check($sformatf("vec%0d_pc_rd", i), {pc, rd}, {vecs[i].pcv, vecs[i].instr[11:7]});
        end
        step();
        check("drain_out_valid", out_valid, 0);

        // Stall: three cycles of back-pressure with a waiting instruction.
        in_valid = 1'b1; out_ready = 1'b1;
        drive(32'h00500093, 32'h100, 32'h0, 32'h0);
        step();
        out_ready = 1'b0;
        drive(32'h402081B3, 32'h104, 32'h10, 32'h3);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_in_ready", in_ready, 0);
            step();
            check("stall_hold", {out_valid, alu_code, op2, pc}, {1'b1, 5'(ALU_ADD), 32'h5, 32'h100});
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("release_next", {out_valid, alu_code, op1, op2, pc}, {1'b1, 5'(ALU_SUB), 32'h10, 32'h3, 32'h104});
        step();
        check("release_no_dup", out_valid, 0);

        // Flush coincident with accepting a JAL.
        in_valid = 1'b1; flush = 1'b1;
        drive(32'h008000EF, 32'h300, 32'h0, 32'h0);
        #1;
        check("flush_in_ready", in_ready, 1);
        step();
        flush = 1'b0;
        check("flush_dropped", out_valid, 0);
        drive(32'h00500093, 32'h104, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        check("after_flush", {out_valid, op2, pc}, {1'b1, 32'h5, 32'h104});
        step();

        // Reset during a stall.
        in_valid = 1'b1; out_ready = 1'b0;
        drive(32'h123452B7, 32'h900, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        check("pre_reset_valid", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset_stall_valid", out_valid, 0);
        check_bundle("reset_stall_bundle", '0);

        // Randomized traffic against the queue model.
        for (int c = 0; c < 1500; c++) begin
            check("rnd_out_valid", out_valid, q.size() != 0);
            if (q.size() != 0 && out_valid) check_bundle("rnd_bundle", q[0]);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            drive(rand_instr(), $urandom & 32'hFFFF_FFFC, $urandom, $urandom);
            #1;
            check("rnd_in_ready", in_ready, (q.size() == 0) || out_ready);
            check("rnd_rs_addr", {rs1_addr, rs2_addr}, {in_instr[19:15], in_instr[24:20]});
            acc = in_valid && ((q.size() == 0) || out_ready);
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(model_decode(in_instr, in_pc, rs1_data, rs2_data));
            if (flush) q.delete();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
